// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// byte-enable lane patterns and the request legality check.
package lsu_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unsigned loads have no store counterpart, so BU/HU stores are rejected.
    function automatic logic req_illegal(input logic we, input logic [2:0] func,
                                         input logic [1:0] off);
        logic ill;
        ill = 1'b1;
        case (func)
            F3_B:    ill = 1'b0;
            F3_H:    ill = off[0];
            F3_W:    ill = (off != 2'b00);
            F3_BU:   ill = we;
            F3_HU:   ill = we | off[0];
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and memory bus signals of the load/store unit.
// master = environment (core + memory), slave = lsu_ctrl.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_func;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_func, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_func, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_ctrl_load_align_extend.sv
// Combinational load path: shifts the addressed lane down to bit 0 and
// sign/zero-extends it according to funct3.
module load_align_extend
    import lsu_ctrl_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [2:0]             func,
    input  logic [1:0]             off,
    input  logic [WORD_LENGTH-1:0] rdata,
    output logic [WORD_LENGTH-1:0] data
);

    logic [WORD_LENGTH-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        data = shifted;
        case (func)
            F3_B:    data = {{(WORD_LENGTH-8){shifted[7]}},   shifted[7:0]};
            F3_H:    data = {{(WORD_LENGTH-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {{(WORD_LENGTH-8){1'b0}},         shifted[7:0]};
            F3_HU:   data = {{(WORD_LENGTH-16){1'b0}},        shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, runs a
// single memory access with timeout, and returns a one-cycle response pulse.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    lsu_ctrl_if.slave  bus
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             func_q, func_d;
    logic [1:0]             off_q, off_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD_LENGTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]             mem_be_q, mem_be_d;
    logic [WORD_LENGTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [WORD_LENGTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;

    logic [3:0]             be_st;
    logic [WORD_LENGTH-1:0] wdata_st;
    logic [WORD_LENGTH-1:0] load_data;

    load_align_extend #(.WORD_LENGTH(WORD_LENGTH)) u_align (
        .func  (func_q),
        .off   (off_q),
        .rdata (bus.mem_rdata),
        .data  (load_data)
    );

    always_comb begin
        be_st    = BE_WORD;
        wdata_st = bus.req_wdata;
        case (bus.req_func)
            F3_B: begin
                be_st    = BE_BYTE << bus.req_addr[1:0];
                wdata_st = {4{bus.req_wdata[7:0]}};
            end
            F3_H: begin
                be_st    = BE_HALF << bus.req_addr[1:0];
                wdata_st = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        func_d       = func_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    func_d       = bus.req_func;
                    off_d        = bus.req_addr[1:0];
                    cnt_d        = 8'd0;
                    resp_rdata_d = '0;
                    if (req_illegal(bus.req_we, bus.req_func, bus.req_addr[1:0])) begin
                        // Rejected requests never touch memory.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = {bus.req_addr[WORD_LENGTH-1:2], 2'b00};
                        mem_be_d    = bus.req_we ? be_st : BE_NONE;
                        mem_wdata_d = bus.req_we ? wdata_st : '0;
                        resp_err_d  = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? '0 : load_data;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIMIT) begin
                        state_d      = ST_RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            func_q       <= 3'd0;
            off_q        <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            func_q       <= func_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter WORD_LENGTH, default 32, data/address width; the block SHALL support only 32.
REQ-002 Parameter TIMEOUT, default 16, max ACCESS cycles without mem_ack before abort; range 1..255.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset_n  in  1  reset; synchronous and active-low.
REQ-005 req_valid  in  1  core requests a load/store.
REQ-006 req_ready  out  1  block accepts a request; high only in IDLE.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_func  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, LSBs significant.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  valid with resp_valid: misaligned, illegal func, or timeout.
REQ-014 mem_req  out  1  memory access request, held until mem_ack.
REQ-015 mem_we  out  1  memory write.
REQ-016 mem_addr  out  32  word-aligned address: req_addr with [1:0] forced to 0.
REQ-017 mem_be  out  4  byte enables; 0000 for loads.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_ack  in  1  memory completes; rdata valid the same cycle.
REQ-020 mem_rdata  in  32  raw word read data.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-022 IDLE: on req_valid && req_ready, the block SHALL register we/func/addr/wdata; legal request -> ACCESS; illegal -> RESP with resp_err=1 and no memory access.
REQ-023 Illegal means func in {011,110,111}, H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-024 ACCESS: mem_req=1 every cycle; mem_we/addr/be/wdata SHALL be stable until ack.
REQ-025 mem_ack in the first ACCESS cycle SHALL be honoured; mem_ack outside ACCESS SHALL be ignored.
REQ-026 On ack the block SHALL register the result and go to RESP.
REQ-027 A cycle counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-028 When the counter reaches TIMEOUT with no ack, the block SHALL enter RESP with resp_err=1; mem_req SHALL drop on the next cycle.
REQ-029 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RESP.
REQ-030 Latency: accept at cycle N, first mem_req at N+1, ack at N+1+k, resp_valid at N+2+k; minimum 2 cycles.
REQ-031 Store mem_be SHALL be B: 0001<<addr[1:0]; H: 0011<<addr[1:0]; W: 1111.
REQ-032 Store mem_wdata SHALL be B: byte replicated x4; H: halfword replicated x2; W: as given.
REQ-033 Load data SHALL be mem_rdata >> (8*addr[1:0]), then sign-extended from bit 7 (B) or 15 (H), zero-extended for BU/HU, passed through for W.
REQ-034 A store with BU/HU func SHALL be illegal (resp_err=1).

Reset
REQ-035 While reset_n=0 at a clock edge: state SHALL be IDLE, the counter 0, and every registered output 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_rdata, resp_err).
REQ-036 req_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-037 Reset mid-ACCESS SHALL abort the access with no response; a pending ack SHALL be ignored.

Structure
REQ-038 A shared package SHALL hold the funct3 encodings, FSM state encoding and lane/byte-enable constants.
REQ-039 Load alignment and extension (REQ-033) SHALL be a combinational sub-module load_align_extend; FSM, counter and store lane logic SHALL stay in lsu_ctrl.

Verification
REQ-040 LB at 0x103, mem_rdata=0x80AABBCC, ack at k=0 -> resp_rdata=0xFFFFFF80, resp_err=0, resp_valid 2 cycles after accept.
REQ-041 SH at 0x202, wdata=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-042 LW at 0x101 -> no mem_req, resp_err=1 one cycle after accept; LHU at 0x102 with rdata 0x8001xxxx -> 0x00008001.
REQ-043 TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then resp_valid=1 with resp_err=1.
REQ-044 reset_n low during ACCESS, ack asserted the next cycle -> no resp_valid, mem_req=0, req_ready=1 after release.
REQ-045 Back-to-back requests with req_valid held high -> second accept only in the IDLE cycle after the RESP pulse.
